mac_result_sink: RTL and testbench

Receiving end of the MAC engine's result handshake. Drives `ready` toward the engine. On every `valid && ready` edge it captures the engine's 20-bit `sum` and the active precision `mode` into a small internal FIFO. It then presents the captured results downstream on a valid/ready stream, with occupancy status and a result counter. It sits between one MAC engine and the output-collection logic, replacing the engine-local output buffer.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/result_fifo.sv | 71 +++++++
 rtl/mac_result_sink.sv | 76 +++++++
 tb/tb_mac_result_sink.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC engine result path: precision mode codes,
// result width and the packed layout of one captured result.
package mac_pkg;

    // Width of the accumulated sum produced by the MAC engine.
    localparam int SUM_W  = 20;

    // Width of the precision mode tag carried with every result.
    localparam int MODE_W = 4;

    // Precision modes the engine can be running in when a result is produced.
    localparam logic [MODE_W-1:0] MODE_2BX2B = 4'd0;
    localparam logic [MODE_W-1:0] MODE_4BX4B = 4'd1;
    localparam logic [MODE_W-1:0] MODE_8BX8B = 4'd2;

    // One captured result: mode tag in the upper bits, sum in the lower bits.
    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [SUM_W-1:0]  sum;
    } result_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO. Push and pop on the same edge are both honoured.
// Pointers wrap naturally; occupancy is tracked by a separate level counter so
// that full and empty are unambiguous. The head entry is read combinationally.
// level_next is exported so a wrapper can register its own readiness from it.
module result_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_next,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + ONE_L;
            2'b01:   level_next = level - ONE_L;
            default: level_next = level;
        endcase
    end

    // Pointer, level and storage update; reset discards all held entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            level <= level_next;
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_result_sink.sv
// Receiving end of the MAC engine result handshake. Each accepted engine
// result (sum plus precision mode) is queued and replayed downstream on a
// valid/ready stream, with occupancy status and a running result count.
// s_ready is a flop, so a pop while full re-enables the engine one cycle later.
module mac_result_sink
    import mac_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = SUM_W,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_sum,
    input  logic [MODE_W-1:0]        s_mode,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [DATA_W-1:0]        m_data,
    output logic [MODE_W-1:0]        m_mode,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [CNT_W-1:0]         result_count
);

    localparam int ENTRY_W = MODE_W + DATA_W;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic               push;
    logic               pop;
    logic               empty;
    logic [LVL_W-1:0]   level_next;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshake mapping: engine side pushes, downstream side pops.
    assign push     = s_valid && s_ready;
    assign pop      = m_valid && m_ready;
    assign wr_entry = {s_mode, s_sum};

    assign m_valid  = !empty;
    assign m_mode   = rd_entry[ENTRY_W-1 -: MODE_W];
    assign m_data   = rd_entry[DATA_W-1:0];

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .wr_data    (wr_entry),
        .pop        (pop),
        .rd_data    (rd_entry),
        .level      (level),
        .level_next (level_next),
        .full       (full),
        .empty      (empty)
    );

    // Registered engine readiness and wrapping count of accepted results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready      <= 1'b0;
            result_count <= '0;
        end else begin
            s_ready <= (level_next < DEPTH_L);
            if (push) begin
                result_count <= result_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_sink.sv
// Directed bench for mac_result_sink with DEPTH=4, DATA_W=20, CNT_W=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mac_result_sink;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [19:0] s_sum;
    logic [3:0]  s_mode;
    logic        s_ready;
    logic        m_valid;
    logic [19:0] m_data;
    logic [3:0]  m_mode;
    logic        m_ready;
    logic [2:0]  level;
    logic        full;
    logic [15:0] result_count;

    int tests;
    int fails;
    logic [15:0] exp_count;

    mac_result_sink #(.DEPTH(4), .DATA_W(20), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_sum        (s_sum),
        .s_mode       (s_mode),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_mode       (m_mode),
        .m_ready      (m_ready),
        .level        (level),
        .full         (full),
        .result_count (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one result, waiting (bounded) for s_ready, then drop valid.
    task automatic push_one(input logic [19:0] d, input logic [3:0] md);
        bit got;
        got = 0;
        s_valid = 1'b1;
        s_sum   = d;
        s_mode  = md;
        for (int k = 0; k < 50; k++) begin
            if (!got && s_ready) got = 1;
            if (!got) tick();
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL push_timeout: s_ready=%0b required=1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        exp_count = exp_count + 16'd1;
    endtask

    // Pop the head (one edge with m_ready) and return what was presented.
    task automatic pop_one(output logic [19:0] d, output logic [3:0] md);
        d  = m_data;
        md = m_mode;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if ({s_ready, m_valid, level, full, result_count} !== 22'd0) begin
            fails++;
            $display("FAIL reset_outputs: got s_ready=%0b m_valid=%0b level=%0d full=%0b count=%0d required all 0",
                     s_ready, m_valid, level, full, result_count);
        end
        rst = 1'b0;
        exp_count = 16'd0;
        tests++;
        if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_early: got %0b required 0", s_ready);
        end
        tick();
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_rise: got %0b required 1", s_ready);
        end
    endtask

    task automatic test_single();
        logic [19:0] d;
        logic [3:0]  md;
        m_ready = 1'b0;
        push_one(20'h0ABCD, 4'd2);
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (m_valid !== 1'b1 || m_data !== 20'h0ABCD || m_mode !== 4'd2 || level !== 3'd1 ||
                result_count !== exp_count) begin
                fails++;
                $display("FAIL single_hold[%0d]: got v=%0b d=%h m=%0d lvl=%0d cnt=%0d required v=1 d=0abcd m=2 lvl=1 cnt=%0d",
                         c, m_valid, m_data, m_mode, level, result_count, exp_count);
            end
            tick();
        end
        pop_one(d, md);
        tests++;
        if (m_valid !== 1'b0 || level !== 3'd0) begin
            fails++;
            $display("FAIL single_drain: got v=%0b lvl=%0d required v=0 lvl=0", m_valid, level);
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] d;
        logic [3:0]  md;
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(20'(i), 4'd1);
        tests++;
        if (full !== 1'b1 || s_ready !== 1'b0 || level !== 3'd4) begin
            fails++;
            $display("FAIL bp_full: got full=%0b s_ready=%0b lvl=%0d required 1 0 4", full, s_ready, level);
        end
        s_valid = 1'b1; s_sum = 20'd5; s_mode = 4'd1;
        repeat (3) tick();
        tests++;
        if (level !== 3'd4 || result_count !== exp_count) begin
            fails++;
            $display("FAIL bp_no_write: got lvl=%0d cnt=%0d required 4 %0d", level, result_count, exp_count);
        end
        pop_one(d, md);
        tests++;
        if (d !== 20'd1 || s_ready !== 1'b1 || level !== 3'd3) begin
            fails++;
            $display("FAIL bp_pop: got d=%0d s_ready=%0b lvl=%0d required 1 1 3", d, s_ready, level);
        end
        tick();
        s_valid = 1'b0;
        exp_count = exp_count + 16'd1;
        tests++;
        if (level !== 3'd4 || result_count !== exp_count) begin
            fails++;
            $display("FAIL bp_accept5: got lvl=%0d cnt=%0d required 4 %0d", level, result_count, exp_count);
        end
        for (int i = 2; i <= 5; i++) begin
            pop_one(d, md);
            tests++;
            if (d !== 20'(i)) begin
                fails++;
                $display("FAIL bp_drain[%0d]: got %0d required %0d", i, d, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] q[$];
        logic [19:0] exp_d;
        logic [19:0] d;
        logic [3:0]  md;
        m_ready = 1'b0;
        push_one(20'h10, 4'd0); q.push_back(20'h10);
        push_one(20'h11, 4'd0); q.push_back(20'h11);
        for (int i = 0; i < 12; i++) begin
            exp_d = q.pop_front();
            q.push_back(20'h12 + 20'(i));
            tests++;
            if (m_data !== exp_d) begin
                fails++;
                $display("FAIL b2b_head[%0d]: got %h required %h", i, m_data, exp_d);
            end
            s_valid = 1'b1; s_sum = 20'h12 + 20'(i); s_mode = 4'd0;
            m_ready = 1'b1;
            tick();
            exp_count = exp_count + 16'd1;
            tests++;
            if (level !== 3'd2) begin
                fails++;
                $display("FAIL b2b_level[%0d]: got %0d required 2", i, level);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        while (q.size() > 0) begin
            exp_d = q.pop_front();
            pop_one(d, md);
            tests++;
            if (d !== exp_d) begin
                fails++;
                $display("FAIL b2b_drain: got %h required %h", d, exp_d);
            end
        end
        tests++;
        if (m_valid !== 1'b0 || result_count !== exp_count) begin
            fails++;
            $display("FAIL b2b_end: got v=%0b cnt=%0d required v=0 cnt=%0d", m_valid, result_count, exp_count);
        end
    endtask

    task automatic test_engine_hold();
        logic [19:0] d;
        logic [3:0]  md;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(20'h100 + 20'(i), 4'd2);
        s_valid = 1'b1; s_sum = 20'h200; s_mode = 4'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (s_ready !== 1'b0 || level !== 3'd4) begin
                fails++;
                $display("FAIL hold_blocked[%0d]: got s_ready=%0b lvl=%0d required 0 4", c, s_ready, level);
            end
        end
        pop_one(d, md);
        tick();
        s_valid = 1'b0;
        exp_count = exp_count + 16'd1;
        tick();
        tests++;
        if (level !== 3'd4 || result_count !== exp_count) begin
            fails++;
            $display("FAIL hold_one_entry: got lvl=%0d cnt=%0d required 4 %0d", level, result_count, exp_count);
        end
        for (int i = 1; i < 4; i++) pop_one(d, md);
        pop_one(d, md);
        tests++;
        if (d !== 20'h200 || md !== 4'd1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_tail: got d=%h m=%0d v=%0b required 00200 1 0", d, md, m_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] d;
        logic [3:0]  md;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(20'h30 + 20'(i), 4'd0);
        tests++;
        if (level !== 3'd3) begin
            fails++;
            $display("FAIL mid_prefill: got lvl=%0d required 3", level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = 16'd0;
        tests++;
        if (level !== 3'd0 || m_valid !== 1'b0 || result_count !== 16'd0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got lvl=%0d v=%0b cnt=%0d s_ready=%0b required 0 0 0 0",
                     level, m_valid, result_count, s_ready);
        end
        push_one(20'hFFFFF, 4'd1);
        tests++;
        if (m_data !== 20'hFFFFF || m_mode !== 4'd1 || result_count !== 16'd1) begin
            fails++;
            $display("FAIL mid_after: got d=%h m=%0d cnt=%0d required fffff 1 1", m_data, m_mode, result_count);
        end
        pop_one(d, md);
    endtask

    task automatic test_count_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m_ready = 1'b1;
        s_valid = 1'b1; s_mode = 4'd0;
        for (int i = 0; i < 65535; i++) begin
            s_sum = 20'(i);
            tick();
        end
        tests++;
        if (result_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_max: got %h required ffff", result_count);
        end
        s_sum = 20'hFFFF;
        tick();
        tests++;
        if (result_count !== 16'h0000 || m_data !== 20'hFFFF) begin
            fails++;
            $display("FAIL wrap_zero: got cnt=%h d=%h required 0000 0ffff", result_count, m_data);
        end
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        tests++;
        if (level !== 3'd0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_drain: got lvl=%0d v=%0b required 0 0", level, m_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_count = 16'd0;
        rst = 1'b1;
        s_valid = 1'b0;
        s_sum = '0;
        s_mode = '0;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_engine_hold();
        test_reset_mid();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
